mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3, number of requesting channels (legal 2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data and mask width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_start  in  NUM_CH  per-channel command request.
REQ-007 req_write  in  NUM_CH  per-channel 1=write, 0=read.
REQ-008 req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata, req_wmask  in  NUM_CH*DATA_W each  per-channel write data and byte-lane mask, packed as in REQ-008.
REQ-010 req_ready  out  NUM_CH  one-hot or zero; command accepted on a channel when req_start and req_ready are both 1.
REQ-011 rsp_rdata  out  DATA_W  read data, shared by all channels.
REQ-012 rsp_valid  out  NUM_CH  one-cycle pulse to the owning channel when rsp_rdata holds its read data.
REQ-013 mem_cmd_start, mem_cmd_write  out  1 each; mem_cmd_ready  in  1  downstream command handshake.
REQ-014 mem_addr  out  ADDR_W; mem_wdata, mem_wmask  out  DATA_W each  downstream command fields.
REQ-015 mem_rdata  in  DATA_W; mem_rdata_valid  in  1  downstream read return.
REQ-016 halt  in  1  blocks new grants.
REQ-017 perf_cycles  out  32; perf_grants  out  NUM_CH*32  statistics; present only under REQ-035.

Function
REQ-018 States: IDLE, ISSUE, WAIT_RD.
REQ-019 In IDLE with halt=0, req_ready SHALL be 1 for exactly one channel: the first channel with req_start=1 searching from (last_grant+1) mod NUM_CH upward, wrapping. This is combinational in IDLE.
REQ-020 If no channel requests, or halt=1, or the state is not IDLE, req_ready SHALL be 0.
REQ-021 On acceptance the arbiter SHALL register owner, write flag, address, wdata and wmask, set last_grant=owner, and enter ISSUE.
REQ-022 In ISSUE the outputs SHALL be mem_cmd_start=1 with the registered fields, held stable until mem_cmd_ready=1.
REQ-023 On the ISSUE cycle with mem_cmd_ready=1: a write SHALL go to IDLE and produce no rsp_valid; a read SHALL go to WAIT_RD.
REQ-024 In WAIT_RD, on mem_rdata_valid=1 the arbiter SHALL register mem_rdata into rsp_rdata, pulse rsp_valid[owner] the next cycle, and return to IDLE.
REQ-025 Latency: acceptance at cycle N gives mem_cmd_start=1 at N+1. mem_rdata_valid at cycle M gives rsp_valid at M+1.
REQ-026 rsp_rdata SHALL hold its value until the next read return.
REQ-027 mem_rdata_valid outside WAIT_RD SHALL be ignored.
REQ-028 Only one transaction SHALL be outstanding at a time; a new grant is possible in the cycle after return to IDLE.
REQ-029 Asserting halt mid-transaction SHALL NOT abort it; the transaction completes and no further grant occurs while halt=1.
REQ-030 A channel's req_start falling after acceptance SHALL NOT affect the registered transaction.

Reset
REQ-031 When rst=1 at a clock edge, the arbiter SHALL enter IDLE and abandon any in-flight transaction.
REQ-032 Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_cmd_start=0, mem_cmd_write=0, mem_addr/mem_wdata/mem_wmask=0.
REQ-033 Reset SHALL set last_grant=NUM_CH-1, so that channel 0 has first priority.
REQ-034 The perf counters (if present) SHALL reset to 0.

Configuration
REQ-035 Macro MEM_ARB_PERF_COUNT_EN. When defined: perf_cycles increments every cycle; perf_grants[i] increments on each acceptance for channel i; both wrap modulo 2^32; both freeze while halt=1. When undefined: the perf ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-036 Reset, then ch1 read addr 0x100 with mem_cmd_ready=1 and mem_rdata=0xDEADBEEF two cycles later -> mem_cmd_start one cycle after acceptance, rsp_valid=3'b010 one cycle after return, rsp_rdata=0xDEADBEEF.
REQ-037 All three channels hold req_start for 6 transactions -> grant order 0,1,2,0,1,2.
REQ-038 ch2 write addr 0x40, data 0x12345678, mask 0xF, with mem_cmd_ready low for 3 cycles -> mem_cmd_start and fields stable for 4 cycles, no rsp_valid, IDLE next.
REQ-039 halt=1 during WAIT_RD with ch0 also requesting -> the read completes, req_ready stays 0 until halt=0, then ch0 is granted.
REQ-040 rst pulsed in WAIT_RD, then a stray mem_rdata_valid -> no rsp_valid, and the next grant goes to channel 0.
REQ-041 With MEM_ARB_PERF_COUNT_EN defined, 5 grants to ch1 over 20 cycles from reset -> perf_grants[ch1]=5 and perf_cycles=20.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting NUM_CH channels access to a single
// memory command port, with one transaction outstanding at a time.
// Optional statistics counters are built when MEM_ARB_PERF_COUNT_EN is defined.
module mem_arbiter #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_start,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*DATA_W-1:0] req_wmask,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic                     mem_cmd_start,
  output logic                     mem_cmd_write,
  input  logic                     mem_cmd_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W-1:0]        mem_wmask,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rdata_valid,
  input  logic                     halt
`ifdef MEM_ARB_PERF_COUNT_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [NUM_CH*32-1:0]     perf_grants
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic             accept;

  // Rotating-priority search starting one past the last granted channel
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_CH);
      if (!grant_vld && req_start[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is offered only while idle and not halted
  always_comb begin
    accept    = (state == IDLE) && !halt && grant_vld;
    req_ready = accept ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // Next-state logic and command strobe
  always_comb begin
    state_nxt     = state;
    mem_cmd_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_cmd_start = 1'b1;
        if (mem_cmd_ready) state_nxt = mem_cmd_write ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rdata_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Owner and round-robin pointer; reset pointer makes channel 0 first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_CH - 1);
      owner      <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      owner      <= grant_idx;
    end
  end

  // Capture the granted channel's command fields; held until the next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cmd_write <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else if (accept) begin
      mem_cmd_write <= req_write[grant_idx];
      mem_addr      <= req_addr[grant_idx*ADDR_W +: ADDR_W];
      mem_wdata     <= req_wdata[grant_idx*DATA_W +: DATA_W];
      mem_wmask     <= req_wmask[grant_idx*DATA_W +: DATA_W];
    end
  end

  // Read return: latch data and pulse the owner's valid one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (state == WAIT_RD && mem_rdata_valid) begin
        rsp_valid <= NUM_CH'(1) << owner;
        rsp_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_PERF_COUNT_EN
  // Statistics counters, frozen while halted, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_grants <= '0;
    end else if (!halt) begin
      perf_cycles <= perf_cycles + 32'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && grant_idx == IDX_W'(i))
          perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, all outputs
// compared each cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int CH = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [CH-1:0]     req_start, req_write, req_ready, rsp_valid;
  logic [CH*AW-1:0]  req_addr;
  logic [CH*DW-1:0]  req_wdata, req_wmask;
  logic [DW-1:0]     rsp_rdata, mem_wdata, mem_wmask, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid, halt;
`ifdef MEM_ARB_PERF_COUNT_EN
  logic [31:0]       perf_cycles;
  logic [CH*32-1:0]  perf_grants;
`endif

  mem_arbiter #(.NUM_CH(CH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_start(req_start), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .halt(halt)
`ifdef MEM_ARB_PERF_COUNT_EN
    , .perf_cycles(perf_cycles), .perf_grants(perf_grants)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: is a transaction in flight, has its command been
  // taken by memory, and what response (if any) is due this cycle.
  bit          m_init = 0;
  bit          m_busy, m_sent, m_wr, m_rsp;
  int          m_last, m_own, m_rsp_ch;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_wmask, m_rdata;
  logic [31:0] m_cycles;
  logic [31:0] m_grants [CH];
  int          glog[$];

  function automatic logic [CH-1:0] exp_ready();
    if (!m_init || m_busy || halt) return '0;
    for (int i = 1; i <= CH; i++) begin
      int c;
      c = (m_last + i) % CH;
      if (req_start[c]) return CH'(1) << c;
    end
    return '0;
  endfunction

  task automatic model_step();
    logic [CH-1:0] r;
    int g;
    r = exp_ready();
    g = 0;
    for (int i = 0; i < CH; i++) if (r[i]) g = i;
    if (rst) begin
      m_init = 1; m_busy = 0; m_sent = 0; m_wr = 0; m_rsp = 0;
      m_last = CH - 1; m_own = 0; m_rsp_ch = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_rdata = '0;
      m_cycles = '0;
      for (int i = 0; i < CH; i++) m_grants[i] = '0;
    end else if (m_init) begin
      m_rsp = 0;
      if (!halt) m_cycles = m_cycles + 32'd1;
      if (r != '0) begin
        m_busy = 1; m_sent = 0; m_own = g; m_last = g;
        m_wr    = req_write[g];
        m_addr  = req_addr[g*AW +: AW];
        m_wdata = req_wdata[g*DW +: DW];
        m_wmask = req_wmask[g*DW +: DW];
        glog.push_back(g);
        m_grants[g] = m_grants[g] + 32'd1;
      end else if (m_busy && !m_sent) begin
        if (mem_cmd_ready) begin
          if (m_wr) m_busy = 0;
          else      m_sent = 1;
        end
      end else if (m_busy && m_sent && mem_rdata_valid) begin
        m_rdata = mem_rdata; m_rsp = 1; m_rsp_ch = m_own;
        m_busy = 0; m_sent = 0;
      end
    end
  endtask

  task automatic check_all();
    if (!m_init) return;
    chk("req_ready", req_ready, exp_ready());
    chk("mem_cmd_start", mem_cmd_start, m_busy && !m_sent);
    chk("mem_cmd_write", mem_cmd_write, m_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_wmask", mem_wmask, m_wmask);
    chk("rsp_valid", rsp_valid, m_rsp ? (CH'(1) << m_rsp_ch) : CH'(0));
    chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef MEM_ARB_PERF_COUNT_EN
    chk("perf_cycles", perf_cycles, m_cycles);
    for (int i = 0; i < CH; i++) chk("perf_grants", perf_grants[i*32 +: 32], m_grants[i]);
`endif
  endtask

  // Advance one clock: model consumes the inputs the DUT samples, then compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1; halt = 0; req_start = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; mem_cmd_ready = 0; mem_rdata_valid = 0;
    mem_rdata = '0;
    tick(); tick();
    rst = 0; #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_start", mem_cmd_start, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick();

    // Channel 1 read of 0x100, data returned two cycles after acceptance
    req_start = 3'b010; req_write = '0; req_addr[1*AW +: AW] = 32'h100; mem_cmd_ready = 1;
    #1 chk("rd_ready_ch1", req_ready, 3'b010);
    tick();
    req_start = '0;
    chk("rd_cmd_start", mem_cmd_start, 1);
    chk("rd_cmd_addr", mem_addr, 32'h100);
    chk("rd_cmd_write", mem_cmd_write, 0);
    tick();
    mem_rdata_valid = 1; mem_rdata = 32'hDEADBEEF;
    chk("rd_no_early_rsp", rsp_valid, 0);
    tick();
    mem_rdata_valid = 0; mem_rdata = '0;
    chk("rd_rsp_valid", rsp_valid, 3'b010);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rsp_pulse", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Round robin with all channels requesting continuously
    rst = 1; tick(); rst = 0;
    glog.delete();
    req_start = 3'b111; req_write = 3'b111; mem_cmd_ready = 1;
    for (int k = 0; k < 60 && glog.size() < 6; k++) tick();
    chk("rr_grant_count", (glog.size() >= 6) ? 6 : glog.size(), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("rr_order", glog[k], k % 3);
    req_start = '0;
    for (int k = 0; k < 3; k++) tick();

    // Channel 2 write with memory back-pressure for three cycles
    req_start = 3'b100; req_write = 3'b100; mem_cmd_ready = 0;
    req_addr[2*AW +: AW] = 32'h40; req_wdata[2*DW +: DW] = 32'h12345678;
    req_wmask[2*DW +: DW] = 32'hF;
    tick();
    req_start = '0;
    for (int k = 0; k < 4; k++) begin
      chk("wr_cmd_start", mem_cmd_start, 1);
      chk("wr_addr", mem_addr, 32'h40);
      chk("wr_wdata", mem_wdata, 32'h12345678);
      chk("wr_wmask", mem_wmask, 32'hF);
      chk("wr_write", mem_cmd_write, 1);
      chk("wr_no_rsp", rsp_valid, 0);
      if (k == 3) mem_cmd_ready = 1;
      tick();
    end
    chk("wr_done", mem_cmd_start, 0);
    chk("wr_no_rsp_after", rsp_valid, 0);
    req_start = 3'b001; req_write = '0; req_addr[0*AW +: AW] = 32'h200;
    #1 chk("wr_idle_next", req_ready, 3'b001);

    // Halt raised while a channel 0 read waits for data
    tick();
    tick();
    halt = 1;
    #1 chk("halt_ready0", req_ready, 0);
    mem_rdata_valid = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rdata_valid = 0;
    chk("halt_rsp_valid", rsp_valid, 3'b001);
    chk("halt_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_blocks", req_ready, 0);
    end
    halt = 0;
    #1 chk("halt_release", req_ready, 3'b001);
    req_start = '0;
    tick();

    // Reset during WAIT_RD, then a stray read return
    req_start = 3'b010; req_addr[1*AW +: AW] = 32'h300;
    tick();
    req_start = '0;
    tick();
    rst = 1; tick(); rst = 0;
    mem_rdata_valid = 1; mem_rdata = 32'h5555AAAA;
    tick();
    mem_rdata_valid = 0;
    chk("stray_no_rsp", rsp_valid, 0);
    req_start = 3'b111;
    #1 chk("post_rst_ch0", req_ready, 3'b001);
    tick();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst             = ($urandom_range(0, 199) == 0);
      halt            = ($urandom_range(0, 7) == 0);
      req_start       = CH'($urandom);
      req_write       = CH'($urandom);
      req_addr        = {$urandom, $urandom, $urandom};
      req_wdata       = {$urandom, $urandom, $urandom};
      req_wmask       = {$urandom, $urandom, $urandom};
      mem_cmd_ready   = 1'($urandom_range(0, 1));
      mem_rdata_valid = ($urandom_range(0, 2) == 0);
      mem_rdata       = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
